// File: rtl/wm_pkg.sv
// Shared mode encodings and the per-bit don't-care rule for the wildcard matcher.
package wm_pkg;

    localparam logic [1:0] WM_EXACT = 2'd0;
    localparam logic [1:0] WM_CASEZ = 2'd1;
    localparam logic [1:0] WM_CASEX = 2'd2;

    // Reserved mode 3 falls through to EXACT, so no bit is ever a don't-care there.
    function automatic logic wm_dc_bit(input logic [1:0] mode,
                                       input logic pz, input logic px,
                                       input logic kz, input logic kx);
        logic dc;
        dc = 1'b0;
        case (mode)
            WM_CASEZ: dc = pz | kz;
            WM_CASEX: dc = pz | px | kz | kx;
            default:  dc = 1'b0;
        endcase
        return dc;
    endfunction

endpackage

// File: rtl/wm_entry_cmp.sv
// Combinational compare of one key against one pattern entry under the request mode.
module wm_entry_cmp
    import wm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   mode,
    input  logic [W-1:0] key,
    input  logic [W-1:0] kz,
    input  logic [W-1:0] kx,
    input  logic         en,
    input  logic [W-1:0] val,
    input  logic [W-1:0] pz,
    input  logic [W-1:0] px,
    output logic         match
);

    logic [W-1:0] bit_ok;

    // A bit agrees when it is a don't-care or its full 4-state encoding is identical.
    always_comb begin
        bit_ok = '0;
        for (int b = 0; b < W; b++) begin
            bit_ok[b] = wm_dc_bit(mode, pz[b], px[b], kz[b], kx[b]) ||
                        ((key[b] == val[b]) && (kz[b] == pz[b]) && (kx[b] == px[b]));
        end
    end

    assign match = en && (&bit_ok);

endmodule

// File: rtl/wildcard_match_unit.sv
// Pattern table plus first-match/multi-match lookup with a one-deep output register
// and saturating hit/miss statistics.
module wildcard_match_unit
    import wm_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [W-1:0]     cfg_val,
    input  logic [W-1:0]     cfg_zmask,
    input  logic [W-1:0]     cfg_xmask,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_key,
    input  logic [W-1:0]     in_kzmask,
    input  logic [W-1:0]     in_kxmask,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic             out_multi,
    output logic [IDX_W-1:0] out_idx,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    logic [DEPTH-1:0]        en_q, en_d;
    logic [DEPTH-1:0][W-1:0] val_q, val_d, zm_q, zm_d, xm_q, xm_d;
    logic [DEPTH-1:0]        match;

    logic             out_valid_q, out_valid_d;
    logic             out_hit_q, out_hit_d;
    logic             out_multi_q, out_multi_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic             accept, any_hit, multi_hit, seen;
    logic [IDX_W-1:0] first_idx;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        wm_entry_cmp #(.W(W)) u_cmp (
            .mode (in_mode),
            .key  (in_key),
            .kz   (in_kzmask),
            .kx   (in_kxmask),
            .en   (en_q[g]),
            .val  (val_q[g]),
            .pz   (zm_q[g]),
            .px   (xm_q[g]),
            .match(match[g])
        );
    end

    // Scan high-to-low so the lowest matching entry is the last assignment.
    always_comb begin
        first_idx = '0;
        multi_hit = 1'b0;
        seen      = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) first_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                if (seen) multi_hit = 1'b1;
                seen = 1'b1;
            end
        end
        any_hit = |match;
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Table writes land on the clock edge, so a same-edge lookup sees the old entry.
    always_comb begin
        en_d  = en_q;
        val_d = val_q;
        zm_d  = zm_q;
        xm_d  = xm_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                en_d[i]  = cfg_en;
                val_d[i] = cfg_val;
                zm_d[i]  = cfg_zmask;
                xm_d[i]  = cfg_xmask;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_multi_d = out_multi_q;
        out_idx_d   = out_idx_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_hit_d   = any_hit;
            out_multi_d = multi_hit;
            out_idx_d   = first_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (accept) begin
            if (any_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= '0;
            val_q       <= '0;
            zm_q        <= '0;
            xm_q        <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_multi_q <= 1'b0;
            out_idx_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            en_q        <= en_d;
            val_q       <= val_d;
            zm_q        <= zm_d;
            xm_q        <= xm_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_multi_q <= out_multi_d;
            out_idx_q   <= out_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_multi = out_multi_q;
    assign out_idx   = out_idx_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_wildcard_match_unit.sv
// Vector-table and scoreboard bench for wildcard_match_unit (small counters to reach saturation).
module tb_wildcard_match_unit;
    import wm_pkg::*;

    localparam int W = 8, DEPTH = 4, CNT_W = 4, IDX_W = 2;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             cfg_we = 1'b0, cfg_en = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [W-1:0]     cfg_val = '0, cfg_zmask = '0, cfg_xmask = '0;
    logic             in_valid = 1'b0, in_ready;
    logic [W-1:0]     in_key = '0, in_kzmask = '0, in_kxmask = '0;
    logic [1:0]       in_mode = '0;
    logic             out_valid, out_ready = 1'b1, out_hit, out_multi;
    logic [IDX_W-1:0] out_idx;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    wildcard_match_unit #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_val(cfg_val), .cfg_zmask(cfg_zmask), .cfg_xmask(cfg_xmask),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_kzmask(in_kzmask), .in_kxmask(in_kxmask), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .out_multi(out_multi), .out_idx(out_idx),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] key, kz, kx;
        logic         hit, multi;
        logic [1:0]   idx;
    } vec_t;

    typedef struct {
        logic       hit, multi;
        logic [1:0] idx;
        int         tag;
    } exp_t;

    exp_t       sb[$];
    int         nchk = 0, nerr = 0, stall_cnt = 0;
    logic [CNT_W-1:0] exp_hit = '0, exp_miss = '0;
    vec_t       v1[8], v2[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result monitor: a result is consumed on the next edge whenever valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL unexpected_result: got hit=%0b idx=%0d with empty scoreboard", out_hit, out_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                nchk++;
                if ({out_hit, out_multi, out_idx} !== {e.hit, e.multi, e.idx}) begin
                    nerr++;
                    $display("FAIL result_%0d: got hit=%0b multi=%0b idx=%0d expected hit=%0b multi=%0b idx=%0d",
                             e.tag, out_hit, out_multi, out_idx, e.hit, e.multi, e.idx);
                end
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic cfg_write(input logic [1:0] idx, input logic en,
                             input logic [W-1:0] v, input logic [W-1:0] z, input logic [W-1:0] x);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_val = v; cfg_zmask = z; cfg_xmask = x;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input vec_t v, input int tag);
        int waited;
        exp_t e;
        in_valid = 1'b1; in_mode = v.mode; in_key = v.key; in_kzmask = v.kz; in_kxmask = v.kx;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++; stall_cnt++;
            @(negedge clk);
        end
        if (!in_ready) begin
            nchk++; nerr++;
            $display("FAIL accept_timeout_%0d: in_ready=0 expected 1 within 20 cycles", tag);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        e.hit = v.hit; e.multi = v.multi; e.idx = v.idx; e.tag = tag;
        sb.push_back(e);
        if (cnt_clr) begin
            exp_hit = '0; exp_miss = '0;
        end else if (v.hit) begin
            if (exp_hit != '1) exp_hit = exp_hit + 1'b1;
        end else begin
            if (exp_miss != '1) exp_miss = exp_miss + 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("latency_%0d", tag), {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
        chk("hit_cnt", {28'd0, hit_cnt}, {28'd0, exp_hit});
        chk("miss_cnt", {28'd0, miss_cnt}, {28'd0, exp_miss});
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [W-1:0] k, input logic [W-1:0] z,
                                input logic [W-1:0] x, input logic h, input logic mu, input logic [1:0] i);
        vec_t v;
        v.mode = m; v.key = k; v.kz = z; v.kx = x; v.hit = h; v.multi = mu; v.idx = i;
        return v;
    endfunction

    initial begin
        // Table 1: entry0 A5/z0F, entry1 3C/x01, entries 2,3 disabled.
        v1[0] = mk(WM_CASEZ, 8'hA0, 8'h00, 8'h00, 1, 0, 0);
        v1[1] = mk(WM_EXACT, 8'hA0, 8'h00, 8'h00, 0, 0, 0);
        v1[2] = mk(WM_CASEZ, 8'h3D, 8'h00, 8'h00, 0, 0, 0);
        v1[3] = mk(WM_CASEX, 8'h3D, 8'h00, 8'h00, 1, 0, 1);
        v1[4] = mk(WM_EXACT, 8'hA5, 8'h0F, 8'h00, 1, 0, 0);
        v1[5] = mk(2'd3,     8'hA5, 8'h0F, 8'h00, 1, 0, 0);
        v1[6] = mk(2'd3,     8'hA0, 8'h00, 8'h00, 0, 0, 0);
        v1[7] = mk(WM_CASEX, 8'h00, 8'hFF, 8'h00, 1, 1, 0);
        // Table 2: entry0 00, entry1 F0/z0F, entry3 FF.
        v2[0] = mk(WM_CASEZ, 8'hFF, 8'h00, 8'h00, 1, 1, 1);
        v2[1] = mk(WM_EXACT, 8'hFF, 8'h00, 8'h00, 1, 0, 3);
        v2[2] = mk(WM_CASEX, 8'h00, 8'hFF, 8'h00, 1, 1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_hit", {31'd0, out_hit}, 0);
        chk("rst_out_idx", {30'd0, out_idx}, 0);
        chk("rst_hit_cnt", {28'd0, hit_cnt}, 0);
        chk("rst_miss_cnt", {28'd0, miss_cnt}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while a result is pending.
        cfg_write(2'd0, 1'b1, 8'hA5, 8'h0F, 8'h00);
        out_ready = 1'b0;
        send(v1[0], 100);
        @(negedge clk);
        chk("pend_valid", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        sb.delete();
        exp_hit = '0; exp_miss = '0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_hit_cnt", {28'd0, hit_cnt}, 0);
        chk("midrst_miss_cnt", {28'd0, miss_cnt}, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(mk(WM_EXACT, 8'h00, 8'h00, 8'h00, 0, 0, 0), 101);
        send(mk(WM_CASEZ, 8'hA0, 8'h00, 8'h00, 0, 0, 0), 102);
        drain();

        cfg_write(2'd0, 1'b1, 8'hA5, 8'h0F, 8'h00);
        cfg_write(2'd1, 1'b1, 8'h3C, 8'h00, 8'h01);
        for (int i = 0; i < 8; i++) send(v1[i], i);
        drain();

        // Output stall: result must hold and in_ready must stay low.
        out_ready = 1'b0;
        send(v1[3], 200);
        in_valid = 1'b1; in_mode = WM_CASEZ; in_key = 8'hA0; in_kzmask = '0; in_kxmask = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 0);
            chk("stall_valid", {31'd0, out_valid}, 1);
            chk("stall_hold", {29'd0, out_hit, out_idx}, {29'd0, 1'b1, 2'd1});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        stall_cnt = 0;
        send(v1[0], 201);
        send(v1[3], 202);
        send(v1[2], 203);
        send(v1[7], 204);
        chk("back_to_back_stalls", stall_cnt, 0);
        drain();

        // Write on the accept edge: lookup must see the old entry0.
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_val = 8'h00; cfg_zmask = '0; cfg_xmask = '0;
        send(mk(WM_CASEZ, 8'hA0, 8'h00, 8'h00, 1, 0, 0), 300);
        cfg_we = 1'b0;
        send(mk(WM_CASEZ, 8'hA0, 8'h00, 8'h00, 0, 0, 0), 301);
        send(mk(WM_EXACT, 8'h00, 8'h00, 8'h00, 1, 0, 0), 302);
        drain();

        cfg_write(2'd1, 1'b1, 8'hF0, 8'h0F, 8'h00);
        cfg_write(2'd3, 1'b1, 8'hFF, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) send(v2[i], 400 + i);
        drain();

        // Saturation, then clear racing an increment.
        for (int i = 0; i < 16; i++) send(v2[1], 500 + i);
        drain();
        chk("hit_sat", {28'd0, hit_cnt}, 32'hF);
        cnt_clr = 1'b1;
        send(v2[1], 600);
        cnt_clr = 1'b0;
        drain();
        chk("clr_hit", {28'd0, hit_cnt}, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", nerr);
        $fatal(1);
    end

endmodule
